// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson-code helpers for the decoder monitor
package johnson_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } jstate_e;

    // Helpers take words zero-extended to this width plus the live width.
    localparam int JC_MAXW = 64;

    function automatic logic [JC_MAXW-1:0] low_mask(input int w);
        logic [JC_MAXW-1:0] m;
        m = (w >= JC_MAXW) ? '1 : ((JC_MAXW'(1) << w) - JC_MAXW'(1));
        return m;
    endfunction

    function automatic int popcount(input logic [JC_MAXW-1:0] v, input int w);
        return $countones(v & low_mask(w));
    endfunction

    // A legal word is a run of ones (MSB=0) or zeros (MSB=1) anchored at the LSB.
    function automatic logic johnson_legal(input logic [JC_MAXW-1:0] c, input int w);
        logic [JC_MAXW-1:0] sh;
        logic [JC_MAXW-1:0] t;
        sh = c >> (w - 1);
        t  = sh[0] ? (~c & low_mask(w)) : (c & low_mask(w));
        return (t & (t + JC_MAXW'(1))) == '0;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson legality check and index decode
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  jc_in,
    output logic          legal,
    output logic [IW-1:0] idx
);

    localparam int IW1 = IW + 1;

    logic [JC_MAXW-1:0] cw;
    logic [IW1-1:0]     pc;
    logic [IW1-1:0]     dec;

    assign cw    = JC_MAXW'(jc_in);
    assign pc    = IW1'(popcount(cw, N));
    // Second half of the cycle counts down as the zeros fill in from the LSB.
    assign dec   = jc_in[N-1] ? (IW1'(2 * N) - pc) : pc;
    assign idx   = dec[IW-1:0];
    assign legal = johnson_legal(cw, N);

endmodule

// File: rtl/johnson_decoder_monitor.sv
// rtl/johnson_decoder_monitor.sv - Johnson decode, sequence lock and error counting
module johnson_decoder_monitor
    import johnson_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 4,
    parameter int ALLOW_HOLD = 1,
    parameter int ECW        = 8,
    localparam int IW        = $clog2(2 * N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           jc_valid,
    input  logic [N-1:0]   jc_in,
    input  logic           err_clr,
    output logic [IW-1:0]  idx,
    output logic           idx_valid,
    output logic           locked,
    output logic           illegal_err,
    output logic           seq_err,
    output logic [ECW-1:0] err_cnt
);

    localparam logic [7:0]    LOCK_MAX = 8'(LOCK_CNT);
    localparam logic [IW-1:0] IDX_LAST = IW'(2 * N - 1);

    jstate_e        state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           idx_valid_q, idx_valid_d;
    logic           have_ref_q, have_ref_d;
    logic [7:0]     good_q, good_d;
    logic           illegal_q, illegal_d;
    logic           seq_q, seq_d;
    logic [ECW-1:0] err_q, err_d;

    logic           dec_legal;
    logic [IW-1:0]  dec_idx;
    logic [IW-1:0]  idx_inc;
    logic           good_step;
    logic           err_event;

    johnson_decode #(.N(N)) u_decode (
        .jc_in (jc_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    assign idx_inc   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    assign good_step = have_ref_q &&
                       ((dec_idx == idx_inc) || ((ALLOW_HOLD != 0) && (dec_idx == idx_q)));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        have_ref_d  = have_ref_q;
        good_d      = good_q;
        illegal_d   = 1'b0;
        seq_d       = 1'b0;
        if (jc_valid) begin
            if (dec_legal) begin
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
                have_ref_d  = 1'b1;
                if (good_step) begin
                    good_d = (good_q >= LOCK_MAX) ? LOCK_MAX : good_q + 8'd1;
                    if (good_d == LOCK_MAX) begin
                        state_d = LOCKED;
                    end
                end else begin
                    good_d = 8'd0;
                    if (state_q == LOCKED) begin
                        seq_d   = 1'b1;
                        state_d = ACQUIRE;
                    end
                end
            end else begin
                illegal_d  = 1'b1;
                have_ref_d = 1'b0;
                good_d     = 8'd0;
                state_d    = ACQUIRE;
            end
        end
    end

    assign err_event = illegal_d | seq_d;

    // A clear that coincides with a fresh error still records that error.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = err_event ? ECW'(1) : '0;
        end else if (err_event && (err_q != '1)) begin
            err_d = err_q + ECW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACQUIRE;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            have_ref_q  <= 1'b0;
            good_q      <= 8'd0;
            illegal_q   <= 1'b0;
            seq_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            have_ref_q  <= have_ref_d;
            good_q      <= good_d;
            illegal_q   <= illegal_d;
            seq_q       <= seq_d;
            err_q       <= err_d;
        end
    end

    assign idx         = idx_q;
    assign idx_valid   = idx_valid_q;
    assign locked      = (state_q == LOCKED);
    assign illegal_err = illegal_q;
    assign seq_err     = seq_q;
    assign err_cnt     = err_q;

endmodule
